// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl: loadable synchronous down counter / timer.
// A start value is accepted over a valid/ready load handshake while idle.
// The counter then decrements to zero and pulses tc at terminal count,
// either stopping (one-shot) or reloading the start value (auto-reload).
//
// Handshake semantics: a load transfers on a posedge where
// load_valid & load_ready are both high. load_ready is high only while idle.
// load_valid may be asserted at any time. A request seen while counting is
// dropped and is not queued.
//
// Optional feature: define DOWN_CTR_PRESCALE_EN to insert a prescaler, so
// that each decrement takes PRESCALE enabled clock cycles. PRESCALE must be >= 2.
// Without the macro, PRESCALE is unused and every enabled cycle is a step.
module down_counter_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic             mode;       // 1 = auto-reload, 0 = one-shot
  logic             handshake;
  logic             step;       // this cycle performs a count step

  // The state is visible directly through load_ready and busy.
  assign load_ready = (state == IDLE);
  assign busy       = (state == COUNT);
  assign handshake  = load_valid & load_ready;

`ifdef DOWN_CTR_PRESCALE_EN
  localparam int PSC_W = $clog2(PRESCALE);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc;

  // A step happens only on the enabled cycle that closes a prescale period.
  assign step = en && (psc == PSC_LAST);

  // The prescaler advances on enabled counting cycles and restarts on load or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc <= '0;
    end else if (handshake || (state == COUNT && abort)) begin
      psc <= '0;
    end else if (state == COUNT && en) begin
      psc <= step ? '0 : psc + PSC_W'(1);
    end
  end
`else
  assign step = en;
`endif

  // The main FSM registers out and tc together with the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out        <= '0;
      tc         <= 1'b0;
      reload_reg <= '0;
      mode       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tc <= 1'b0;
          if (handshake) begin
            if (load_value != '0) begin
              out        <= load_value;
              reload_reg <= load_value;
              mode       <= auto_reload;
              state      <= COUNT;
            end else begin
              // A zero load completes immediately. There is no zero-period reload.
              out <= '0;
              tc  <= 1'b1;
            end
          end
        end
        COUNT: begin
          if (abort) begin
            // Abort takes priority over a coincident terminal step.
            out   <= '0;
            tc    <= 1'b0;
            state <= IDLE;
          end else if (!step) begin
            tc <= 1'b0;
          end else if (out > WIDTH'(1)) begin
            out <= out - WIDTH'(1);
            tc  <= 1'b0;
          end else if (mode) begin
            // In reload mode, out goes from 1 directly to the reload value.
            out <= reload_reg;
            tc  <= 1'b1;
          end else begin
            out   <= '0;
            tc    <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          out   <= '0;
          tc    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Testbench for down_counter_ctrl.
// The bench model tracks the start value, the remaining count and the number of
// enabled sub-steps directly from the counter rules. It is checked against the
// DUT on every cycle. Directed sequences add hand-computed literal expectations.
module tb_down_counter_ctrl;

  localparam int WIDTH = 4;
`ifdef DOWN_CTR_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             auto_reload = 1'b0;
  logic             en = 1'b0;
  logic             abort = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             tc;

  always #5 clk = ~clk;

  down_counter_ctrl #(
    .WIDTH   (WIDTH),
    .PRESCALE(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .en         (en),
    .abort      (abort),
    .out        (out),
    .busy       (busy),
    .tc         (tc)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_out    = 0;  // value the count shows
  int m_period = 0;  // start value captured at load
  int m_sub    = 0;  // enabled cycles since the last step
  bit m_active = 0;  // a count is in progress
  bit m_rel    = 0;  // auto-reload mode
  bit m_tc     = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_out = 0; m_period = 0; m_sub = 0; m_active = 0; m_rel = 0; m_tc = 0;
    end else if (!m_active) begin
      m_tc = 0;
      if (load_valid) begin
        if (load_value == 0) begin
          m_out = 0;
          m_tc  = 1;
        end else begin
          m_out = load_value; m_period = load_value; m_rel = auto_reload;
          m_active = 1; m_sub = 0;
        end
      end
    end else if (abort) begin
      m_active = 0; m_out = 0; m_tc = 0; m_sub = 0;
    end else begin
      m_tc = 0;
      if (en) begin
        m_sub = m_sub + 1;
        if (m_sub == PS) begin
          m_sub = 0;
          if (m_out == 1) begin
            m_tc = 1;
            if (m_rel) m_out = m_period;
            else begin
              m_out = 0;
              m_active = 0;
            end
          end else begin
            m_out = m_out - 1;
          end
        end
      end
    end
  end

  // Compare the DUT against the model every cycle, 1 ns after the edge.
  always @(posedge clk) begin
    #1;
    check("cyc_out", int'(out), m_out);
    check("cyc_busy", int'(busy), int'(m_active));
    check("cyc_load_ready", int'(load_ready), int'(!m_active));
    check("cyc_tc", int'(tc), int'(m_tc));
  end

  // ---------------- driver ----------------
  // Apply inputs at the falling edge. Return 1 ns after the next rising edge.
  task automatic drive(input logic lv, input logic [WIDTH-1:0] val, input logic ar,
                       input logic e, input logic ab);
    @(negedge clk);
    load_valid  = lv;
    load_value  = val;
    auto_reload = ar;
    en          = e;
    abort       = ab;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out", int'(out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(load_ready), 1);
    check("rst_tc", int'(tc), 0);
    rst = 1'b0;

`ifndef DOWN_CTR_PRESCALE_EN
    // T1: reset in the middle of a count
    drive(1, 4'd8, 0, 1, 0);
    check("t1_load", int'(out), 8);
    repeat (3) drive(0, 4'd0, 0, 1, 0);
    check("t1_at5", int'(out), 5);
    rst = 1'b1;
    drive(0, 4'd0, 0, 1, 0);
    drive(0, 4'd0, 0, 1, 0);
    check("t1_rst_out", int'(out), 0);
    check("t1_rst_busy", int'(busy), 0);
    check("t1_rst_tc", int'(tc), 0);
    check("t1_rst_ready", int'(load_ready), 1);
    rst = 1'b0;

    // T2: one-shot count from 4
    drive(1, 4'd4, 0, 1, 0);
    check("t2_load", int'(out), 4);
    check("t2_ready_low", int'(load_ready), 0);
    exp_q = '{4'd3, 4'd2, 4'd1};
    while (exp_q.size() > 0) begin
      drive(0, 4'd0, 0, 1, 0);
      check("t2_out", int'(out), int'(exp_q.pop_front()));
      check("t2_no_tc", int'(tc), 0);
    end
    drive(0, 4'd0, 0, 1, 0);
    check("t2_term_out", int'(out), 0);
    check("t2_term_tc", int'(tc), 1);
    check("t2_term_ready", int'(load_ready), 1);
    drive(0, 4'd0, 0, 1, 0);
    check("t2_tc_drop", int'(tc), 0);

    // T3: auto-reload from 3
    drive(1, 4'd3, 1, 1, 0);
    check("t3_load", int'(out), 3);
    exp_q = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1};
    while (exp_q.size() > 0) begin
      drive(0, 4'd0, 0, 1, 0);
      check("t3_tc", int'(tc), (exp_q[0] == 4'd3) ? 1 : 0);
      check("t3_out", int'(out), int'(exp_q.pop_front()));
      check("t3_busy", int'(busy), 1);
    end
    drive(0, 4'd0, 0, 1, 1);
    check("t3_abort_busy", int'(busy), 0);

    // T4: pause then abort on the out==1 cycle
    drive(1, 4'd6, 0, 1, 0);
    drive(0, 4'd0, 0, 1, 0);
    drive(0, 4'd0, 0, 1, 0);
    check("t4_at4", int'(out), 4);
    repeat (3) begin
      drive(0, 4'd0, 0, 0, 0);
      check("t4_hold", int'(out), 4);
    end
    exp_q = '{4'd3, 4'd2, 4'd1};
    while (exp_q.size() > 0) begin
      drive(0, 4'd0, 0, 1, 0);
      check("t4_out", int'(out), int'(exp_q.pop_front()));
    end
    drive(0, 4'd0, 0, 1, 1);
    check("t4_abort_out", int'(out), 0);
    check("t4_abort_tc", int'(tc), 0);
    check("t4_abort_idle", int'(load_ready), 1);
    drive(0, 4'd0, 0, 1, 1);
    check("t4_idle_abort", int'(busy), 0);

    // T5: zero load, max load, load during count
    drive(1, 4'd0, 1, 1, 0);
    check("t5_zero_out", int'(out), 0);
    check("t5_zero_tc", int'(tc), 1);
    check("t5_zero_idle", int'(busy), 0);
    drive(0, 4'd0, 0, 1, 0);
    check("t5_zero_tc_drop", int'(tc), 0);
    drive(1, 4'd15, 0, 1, 0);
    check("t5_max_load", int'(out), 15);
    for (int k = 1; k <= 15; k++) begin
      drive((k == 5), 4'd9, 1, 1, 0);
      check("t5_max_out", int'(out), 15 - k);
      check("t5_max_tc", int'(tc), (k == 15) ? 1 : 0);
    end
`else
    // T6: prescale by 4, load 2
    drive(1, 4'd2, 0, 1, 0);
    check("t6_load", int'(out), 2);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 4'd0, 0, 1, 0);
      check("t6_out", int'(out), (k < 4) ? 2 : ((k < 8) ? 1 : 0));
      check("t6_tc", int'(tc), (k == 8) ? 1 : 0);
    end
`endif

    // Mixed run: auto-reload with irregular enable, then abort (model only)
    drive(1, 4'd5, 1, 1, 0);
    for (int k = 0; k < 40; k++) begin
      drive((k == 7), 4'd2, 0, (k % 3 != 0), 0);
    end
    drive(0, 4'd0, 0, 1, 1);
    drive(0, 4'd0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
